fp16_accumulator: RTL and testbench
===================================

// Module: fp16_accumulator
// PURPOSE
//  Downstream consumer of the FP16 adder function library in the systolic-array PE/column drain path.
//  Accepts a stream of FP16 partial products over valid/ready and sums K_LEN of them left-to-right.
//  Each step uses fp16_add(acc, in_data) from function_lib_fp16_add.
//  Presents each K_LEN-term sum on an output valid/ready port, then restarts from zero.
// PARAMETERS
//  K_LEN  16                    number of input beats summed per output (>=1)
//  CNT_W  $clog2(K_LEN+1)       width of beat counter
// PORTS
//  clk        in   1   clock, all logic rising-edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   in_data valid
//  in_ready   out  1   block can accept in_data
//  in_data    in   16  FP16 operand {sign,exp[4:0],mant[9:0]}
//  out_valid  out  1   out_data holds a completed sum
//  out_ready  in   1   downstream accepts out_data
//  out_data   out  16  FP16 sum of last K_LEN accepted beats
//  out_ovf    out  1   overflow flag (present only with FP16_ACC_OVF_FLAG_EN)
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). Reset values:
//    state=ACC, acc=16'h0000, cnt=0, in_ready=1, out_valid=0, out_data=16'h0000, out_ovf=0.
//  - States:
//    ACC: in_ready=1, out_valid=0.
//      On in_valid&in_ready: acc<=fp16_add(acc,in_data) and cnt<=cnt+1.
//      On the beat where cnt==K_LEN-1: out_data<=fp16_add(acc,in_data), acc<=0, cnt<=0, go HOLD.
//    HOLD: in_ready=0, out_valid=1, out_data stable.
//      On out_ready: go ACC next cycle.
//      No input is accepted in the same cycle as the output handshake (in_ready is 0 in HOLD).
//  - Latency: out_valid rises the cycle after the K_LEN-th input handshake.
//    Maximum throughput is K_LEN beats per K_LEN+1 cycles.
//  - in_ready and out_valid are registered-state decodes only. There is no combinational path from
//    in_valid or out_ready to either output.
//  - Arithmetic is exactly fp16_add, so sums are bit-exact to the library:
//      truncating alignment and normalisation, no rounding;
//      exactly cancelling operands give +0 (16'h0000);
//      a 0 operand passes the other operand through unchanged;
//      negative exponent after normalisation flushes to 16'h0000;
//      no NaN/Inf/denormal special-casing;
//      exponent field 5'h1F is produced as a plain bit pattern.
//  - Summation order is fixed: (((0+x0)+x1)+...)+x(K_LEN-1), with x0 the first accepted beat.
//  - in_valid low in ACC: state, acc and cnt hold; gaps of any length are allowed.
//  - out_ready high in ACC is ignored.
//  - in_data is sampled only on a handshake; its value is don't-care otherwise.
//  - rst asserted mid-accumulation or in HOLD: the partial sum or pending output is discarded and
//    all state returns to reset values next cycle.
//  - K_LEN=1: every accepted beat produces out_data=fp16_add(0,x)=x.
// CONFIGURATION
//  FP16_ACC_OVF_FLAG_EN defined:
//    - Port out_ovf exists. A sticky internal ovf bit is set when any step's result has
//      exponent field 5'h1F.
//    - On entry to HOLD, out_ovf <= ovf | (final step overflowed), and ovf clears.
//    - out_ovf is valid with out_valid and reads 0 in ACC.
//    - rst clears ovf and out_ovf.
//  FP16_ACC_OVF_FLAG_EN undefined: no out_ovf port and no overflow logic; all other behaviour
//  is identical.
// TESTING
//  1 K_LEN=4; in 3C00,3C00,3C00,3C00 back-to-back -> out_valid 1 cycle after 4th beat, out_data=4400.
//  2 K_LEN=4; in 3C00,BC00,4000,C000 with in_valid gaps -> out_data=0000, and in_ready=0 while in HOLD.
//  3 K_LEN=4; hold out_ready=0 for 5 cycles in HOLD -> out_data stable, in_ready=0, no beat accepted;
//    then out_ready=1 -> next group 4000 x4 -> out_data=4800.
//  4 K_LEN=4; assert rst for 1 cycle after 2 beats of 3C00, then 4200 x4 ->
//    out_data=4A00 (partial sum discarded).
//  5 (OVF_EN) K_LEN=2; in 7800,7800 -> out_data=7C00, out_ovf=1;
//    next group 3C00,3C00 -> out_data=4000, out_ovf=0.
//  6 K_LEN=1; in 0000, then 8000 -> out_data=0000, then 8000 (zero pass-through).

Source files
------------

// File: rtl/fp16_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fp16_accumulator
// Description : Sums K_LEN FP16 beats accepted over valid/ready, left to right,
//               with a truncating FP16 adder. Each sum is presented on an
//               output valid/ready port, then the block restarts from zero.
//               Optional macro FP16_ACC_OVF_FLAG_EN adds a sticky overflow
//               flag (out_ovf) that is reported with each sum.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_accumulator #(
  parameter int K_LEN = 16,
  parameter int CNT_W = $clog2(K_LEN + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
`ifdef FP16_ACC_OVF_FLAG_EN
  ,
  output logic        out_ovf
`endif
);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(K_LEN - 1);

  // Truncating FP16 add: no rounding, no special values, zero passes through,
  // exact cancellation gives +0, negative exponent flushes to +0.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  d;
    logic [10:0] mx;
    logic [10:0] mys;
    logic [11:0] s;
    logic [10:0] norm;
    logic [4:0]  lz;
    logic [15:0] res;
    res = 16'h0000;
    if (a[14:0] == 15'd0) begin
      res = b;
    end else if (b[14:0] == 15'd0) begin
      res = a;
    end else begin
      // x is the operand with the larger magnitude; its sign wins
      if (a[14:0] >= b[14:0]) begin
        x = a;
        y = b;
      end else begin
        x = b;
        y = a;
      end
      d   = x[14:10] - y[14:10];
      mx  = {1'b1, x[9:0]};
      mys = (d > 5'd10) ? 11'd0 : ({1'b1, y[9:0]} >> d);
      if (x[15] == y[15]) begin
        s = {1'b0, mx} + {1'b0, mys};
        if (s[11]) begin
          res = {x[15], x[14:10] + 5'd1, s[10:1]};
        end else begin
          res = {x[15], x[14:10], s[9:0]};
        end
      end else begin
        s = {1'b0, mx} - {1'b0, mys};
        if (s == 12'd0) begin
          res = 16'h0000;
        end else begin
          // leading-zero count relative to the hidden-bit position
          lz = 5'd0;
          for (int i = 0; i <= 10; i++) begin
            if (s[i]) lz = 5'(10 - i);
          end
          norm = s[10:0] << lz;
          if (lz > x[14:10]) begin
            res = 16'h0000;
          end else begin
            res = {x[15], x[14:10] - lz, norm[9:0]};
          end
        end
      end
    end
    return res;
  endfunction

  state_t           r_state;
  state_t           w_state_n;
  logic [15:0]      r_acc;
  logic [15:0]      w_acc_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_n;
  logic [15:0]      r_out_data;
  logic [15:0]      w_out_data_n;
  logic [15:0]      w_sum;
  logic             w_fire;
  logic             w_last;

  // Next-state, datapath update and handshake decodes
  always_comb begin
    w_state_n    = r_state;
    w_acc_n      = r_acc;
    w_cnt_n      = r_cnt;
    w_out_data_n = r_out_data;
    in_ready     = (r_state == ACC);
    out_valid    = (r_state == HOLD);
    w_fire       = in_valid && (r_state == ACC);
    w_last       = (r_cnt == c_last_cnt);
    w_sum        = fp16_add(r_acc, in_data);
    case (r_state)
      ACC: begin
        if (w_fire) begin
          if (w_last) begin
            w_out_data_n = w_sum;
            w_acc_n      = 16'h0000;
            w_cnt_n      = '0;
            w_state_n    = HOLD;
          end else begin
            w_acc_n = w_sum;
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) w_state_n = ACC;
      end
      default: w_state_n = ACC;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACC;
      r_acc      <= 16'h0000;
      r_cnt      <= '0;
      r_out_data <= 16'h0000;
    end else begin
      r_state    <= w_state_n;
      r_acc      <= w_acc_n;
      r_cnt      <= w_cnt_n;
      r_out_data <= w_out_data_n;
    end
  end

  assign out_data = r_out_data;

`ifdef FP16_ACC_OVF_FLAG_EN
  logic r_ovf;
  logic r_out_ovf;
  logic w_step_ovf;

  assign w_step_ovf = (w_sum[14:10] == 5'h1F);

  // Sticky per-group overflow, transferred to out_ovf on entry to HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf     <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (w_fire && w_last) begin
      r_out_ovf <= r_ovf | w_step_ovf;
      r_ovf     <= 1'b0;
    end else if (w_fire) begin
      r_ovf <= r_ovf | w_step_ovf;
    end else if (r_state == HOLD && out_ready) begin
      r_out_ovf <= 1'b0;
    end
  end

  assign out_ovf = r_out_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_accumulator
// Description : Self-checking bench for fp16_accumulator (K_LEN=4, 1 and 2
//               instances), vector table plus randomized groups against an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic [15:0] in_data4 = 16'h0, out_data4;
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [15:0] in_data1 = 16'h0, out_data1;
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [15:0] in_data2 = 16'h0, out_data2;
`ifdef FP16_ACC_OVF_FLAG_EN
  logic ovf4, ovf1, ovf2;
`endif

  fp16_accumulator #(.K_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
`ifdef FP16_ACC_OVF_FLAG_EN
    , .out_ovf(ovf4)
`endif
  );

  fp16_accumulator #(.K_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
`ifdef FP16_ACC_OVF_FLAG_EN
    , .out_ovf(ovf1)
`endif
  );

  fp16_accumulator #(.K_LEN(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
`ifdef FP16_ACC_OVF_FLAG_EN
    , .out_ovf(ovf2)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: value = sig * 2^exp with integers; smaller operand's
  // significand is floor-divided to the larger exponent, then renormalised.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml;
    int d, e, sig_big, sig_sml, total;
    if (a[14:0] == 15'd0) return b;
    if (b[14:0] == 15'd0) return a;
    if (int'(a[14:0]) >= int'(b[14:0])) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    e       = int'(big[14:10]);
    d       = e - int'(sml[14:10]);
    sig_big = 1024 + int'(big[9:0]);
    sig_sml = (1024 + int'(sml[9:0])) >> d;
    total   = (big[15] == sml[15]) ? sig_big + sig_sml : sig_big - sig_sml;
    if (total == 0) return 16'h0000;
    while (total >= 2048) begin total = total / 2; e++; end
    while (total < 1024) begin total = total * 2; e--; end
    if (e < 0) return 16'h0000;
    return {big[15], 5'(e), 10'(total)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into the K_LEN=4 instance after `gap` idle cycles
  task automatic push4(input logic [15:0] d, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid4 = 1'b0;
      in_data4  = 16'($urandom);
      tick();
    end
    in_valid4 = 1'b1;
    in_data4  = d;
    t = 0;
    while (!in_ready4 && t < 50) begin
      tick();
      t++;
    end
    chk("in_ready_wait", {31'd0, in_ready4}, 32'd1);
    tick();
    in_valid4 = 1'b0;
    in_data4  = 16'($urandom);
  endtask

  // Called right after the last beat: check HOLD, wait `dly`, then handshake
  task automatic drain4(input string name, input logic [15:0] exp, input int dly);
    chk({name, "_valid"}, {31'd0, out_valid4}, 32'd1);
    chk({name, "_data"}, {16'd0, out_data4}, {16'd0, exp});
    chk({name, "_inrdy0"}, {31'd0, in_ready4}, 32'd0);
    out_ready4 = 1'b0;
    for (int i = 0; i < dly; i++) tick();
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk({name, "_back_acc"}, {30'd0, in_ready4, out_valid4}, 32'd2);
  endtask

  typedef struct {
    logic [15:0] d [4];
    logic [15:0] exp;
    int          gap;
  } vec_t;

  vec_t tbl [7];
  logic [15:0] grp [4];
  logic [15:0] model;
  logic [15:0] held;

  initial begin
    tbl[0].d = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}; tbl[0].exp = 16'h4400; tbl[0].gap = 0;
    tbl[1].d = '{16'h3C00, 16'hBC00, 16'h4000, 16'hC000}; tbl[1].exp = 16'h0000; tbl[1].gap = 2;
    tbl[2].d = '{16'h4000, 16'h4000, 16'h4000, 16'h4000}; tbl[2].exp = 16'h4800; tbl[2].gap = 0;
    tbl[3].d = '{16'h3C00, 16'h3400, 16'h3400, 16'h3400}; tbl[3].exp = 16'h3F00; tbl[3].gap = 1;
    tbl[4].d = '{16'h6800, 16'h3C00, 16'h3C00, 16'h3C00}; tbl[4].exp = 16'h6800; tbl[4].gap = 0;
    tbl[5].d = '{16'h0401, 16'h8400, 16'h0000, 16'h0000}; tbl[5].exp = 16'h0000; tbl[5].gap = 3;
    tbl[6].d = '{16'h4000, 16'h0000, 16'h8000, 16'h3C00}; tbl[6].exp = 16'h4200; tbl[6].gap = 0;

    tick();
    tick();
    rst = 1'b0;
    chk("reset_k4", {15'd0, in_ready4, out_valid4, out_data4}, {15'd0, 1'b1, 1'b0, 16'h0000});
    chk("reset_k1", {15'd0, in_ready1, out_valid1, out_data1}, {15'd0, 1'b1, 1'b0, 16'h0000});
`ifdef FP16_ACC_OVF_FLAG_EN
    chk("reset_ovf", {31'd0, ovf4}, 32'd0);
`endif

    // vector table
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3) chk($sformatf("vec%0d_pre_valid", v), {31'd0, out_valid4}, 32'd0);
        push4(tbl[v].d[k], tbl[v].gap);
      end
      drain4($sformatf("vec%0d", v), tbl[v].exp, v % 3);
    end

    // HOLD stalls while in_valid offers junk; nothing must be taken
    for (int k = 0; k < 4; k++) push4(16'h3C00, 0);
    held = out_data4;
    chk("stall_enter", {16'd0, held}, {16'd0, 16'h4400});
    in_valid4 = 1'b1;
    in_data4  = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d", i), {14'd0, out_valid4, in_ready4, out_data4}, {14'd0, 1'b1, 1'b0, held});
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    for (int k = 0; k < 4; k++) push4(16'h4000, 0);
    drain4("after_stall", 16'h4800, 0);

    // reset mid-group discards the partial sum
    push4(16'h3C00, 0);
    push4(16'h3C00, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst", {15'd0, in_ready4, out_valid4, out_data4}, {15'd0, 1'b1, 1'b0, 16'h0000});
    for (int k = 0; k < 4; k++) push4(16'h4200, 0);
    drain4("after_rst", 16'h4A00, 1);

    // reset while HOLD
    for (int k = 0; k < 4; k++) push4(16'h3C00, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold_rst", {15'd0, in_ready4, out_valid4, out_data4}, {15'd0, 1'b1, 1'b0, 16'h0000});

    // K_LEN=1 zero pass-through
    in_valid1 = 1'b1; in_data1 = 16'h0000; tick(); in_valid1 = 1'b0;
    chk("k1_zero", {15'd0, out_valid1, in_ready1, out_data1}, {15'd0, 1'b1, 1'b0, 16'h0000});
    out_ready1 = 1'b1; tick(); out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'h8000; tick(); in_valid1 = 1'b0;
    chk("k1_negzero", {15'd0, out_valid1, in_ready1, out_data1}, {15'd0, 1'b1, 1'b0, 16'h8000});
    out_ready1 = 1'b1; tick(); out_ready1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'hC2A5; tick(); in_valid1 = 1'b0;
    chk("k1_pass", {16'd0, out_data1}, {16'd0, 16'hC2A5});
    out_ready1 = 1'b1; tick(); out_ready1 = 1'b0;
    chk("k1_back", {31'd0, in_ready1}, 32'd1);

    // K_LEN=2 overflow group then clean group
    in_valid2 = 1'b1; in_data2 = 16'h7800; tick(); tick(); in_valid2 = 1'b0;
    chk("k2_big", {15'd0, out_valid2, out_data2}, {15'd0, 1'b1, 16'h7C00});
`ifdef FP16_ACC_OVF_FLAG_EN
    chk("k2_ovf1", {31'd0, ovf2}, 32'd1);
`endif
    out_ready2 = 1'b1; tick(); out_ready2 = 1'b0;
`ifdef FP16_ACC_OVF_FLAG_EN
    chk("k2_ovf_acc", {31'd0, ovf2}, 32'd0);
`endif
    in_valid2 = 1'b1; in_data2 = 16'h3C00; tick(); tick(); in_valid2 = 1'b0;
    chk("k2_small", {15'd0, out_valid2, out_data2}, {15'd0, 1'b1, 16'h4000});
`ifdef FP16_ACC_OVF_FLAG_EN
    chk("k2_ovf0", {31'd0, ovf2}, 32'd0);
`endif
    out_ready2 = 1'b1; tick(); out_ready2 = 1'b0;

    // randomized groups, out_ready toggled in ACC (must be ignored)
    for (int g = 0; g < 40; g++) begin
      model = 16'h0000;
      for (int k = 0; k < 4; k++) begin
        grp[k] = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
        if ($urandom_range(0, 7) == 0) grp[k] = {1'($urandom), 15'd0};
        model = ref_add(model, grp[k]);
      end
      for (int k = 0; k < 4; k++) begin
        out_ready4 = (k < 3) ? 1'($urandom) : 1'b0;
        push4(grp[k], $urandom_range(0, 2));
      end
      out_ready4 = 1'b0;
      drain4($sformatf("rnd%0d", g), model, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
